// File: rtl/multi_countdown_timer.sv
// Multi-channel HH:MM:SS BCD countdown timer with per-channel preset, run/pause,
// latched alarm and optional auto-reload; one channel is selected for edit/display.
module multi_countdown_timer #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int CHANNELS    = 4,
    parameter int MAX_HOUR    = 99,
    parameter bit AUTO_RELOAD = 1'b0,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_start,
    input  logic                btn_cancel,
    input  logic                btn_ch,
    input  logic                btn_next,
    input  logic                btn_inc,
    input  logic                btn_dec,
    output logic [CW-1:0]       ch_sel,
    output logic [23:0]         value,
    output logic [1:0]          cursor_pos,
    output logic [CHANNELS-1:0] running,
    output logic [CHANNELS-1:0] alert
);

    localparam int         DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [6:0] HMAX = 7'(MAX_HOUR);

    typedef enum logic [1:0] {ST_SET, ST_RUN, ST_PAUSE, ST_DONE} state_t;
    typedef enum logic [1:0] {FLD_HOUR = 2'd1, FLD_MIN = 2'd2, FLD_SEC = 2'd3} field_t;

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = v / 7'd10;
        ones = v - tens * 7'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

    // Wrapping step of one two-digit BCD field in 0..fmax.
    function automatic logic [7:0] step_field(input logic [7:0] f, input logic [6:0] fmax,
                                              input logic up);
        logic [6:0] v;
        v = bcd_to_bin(f);
        if (up) v = (v >= fmax) ? 7'd0 : v + 7'd1;
        else    v = (v == 7'd0) ? fmax : v - 7'd1;
        return bin_to_bcd(v);
    endfunction

    function automatic logic [23:0] dec_time(input logic [23:0] t);
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        h = t[23:16];
        m = t[15:8];
        s = t[7:0];
        if (s == 8'h00) begin
            if (m == 8'h00) h = step_field(h, HMAX, 1'b0);
            m = step_field(m, 7'd59, 1'b0);
        end
        s = step_field(s, 7'd59, 1'b0);
        return {h, m, s};
    endfunction

    logic [DW-1:0]       r_div;
    logic [CW-1:0]       r_ch_sel;
    field_t              r_field;
    state_t              r_state  [CHANNELS];
    logic [23:0]         r_preset [CHANNELS];
    logic [23:0]         r_cnt    [CHANNELS];
    logic [CHANNELS-1:0] r_running;
    logic [CHANNELS-1:0] r_alert;

    logic                w_tick;
    logic                w_do_start, w_do_cancel, w_do_ch, w_do_next, w_do_inc, w_do_dec;
    logic [CW-1:0]       w_ch_nxt;
    field_t              w_field_nxt;
    state_t              w_state_nxt  [CHANNELS];
    logic [23:0]         w_preset_nxt [CHANNELS];
    logic [23:0]         w_cnt_nxt    [CHANNELS];
    logic [CHANNELS-1:0] w_alert_nxt;
    logic [CHANNELS-1:0] w_sel;
    logic [CHANNELS-1:0] w_hold;

    assign w_tick = (r_div == DW'(TICK_DIV - 1));

    always_comb begin
        w_do_start  = btn_start;
        w_do_cancel = !btn_start && btn_cancel;
        w_do_ch     = !btn_start && !btn_cancel && btn_ch;
        w_do_next   = !btn_start && !btn_cancel && !btn_ch && btn_next;
        w_do_inc    = !btn_start && !btn_cancel && !btn_ch && !btn_next && btn_inc;
        w_do_dec    = !btn_start && !btn_cancel && !btn_ch && !btn_next && !btn_inc && btn_dec;
    end

    always_comb begin
        w_ch_nxt    = r_ch_sel;
        w_field_nxt = r_field;
        if (w_do_ch) begin
            w_ch_nxt    = (r_ch_sel == CW'(CHANNELS - 1)) ? '0 : r_ch_sel + 1'b1;
            w_field_nxt = FLD_HOUR;
        end else if (w_do_next) begin
            case (r_field)
                FLD_HOUR: w_field_nxt = FLD_MIN;
                FLD_MIN:  w_field_nxt = FLD_SEC;
                default:  w_field_nxt = FLD_HOUR;
            endcase
        end
    end

    // Button actions on the selected channel first; w_hold blocks that cycle's decrement.
    always_comb begin
        w_alert_nxt = r_alert;
        w_sel       = '0;
        w_hold      = '0;
        for (int unsigned i = 0; i < unsigned'(CHANNELS); i++) begin
            w_state_nxt[i]  = r_state[i];
            w_preset_nxt[i] = r_preset[i];
            w_cnt_nxt[i]    = r_cnt[i];
            w_sel[i]        = (r_ch_sel == CW'(i));
            if (w_sel[i] && w_do_start) begin
                case (r_state[i])
                    ST_SET: if (r_preset[i] != '0) begin
                        w_state_nxt[i] = ST_RUN;
                        w_cnt_nxt[i]   = r_preset[i];
                        w_hold[i]      = 1'b1;
                    end
                    ST_RUN: if (r_alert[i]) begin
                        w_alert_nxt[i] = 1'b0;
                    end else begin
                        w_state_nxt[i] = ST_PAUSE;
                        w_hold[i]      = 1'b1;
                    end
                    ST_PAUSE: begin
                        w_state_nxt[i] = ST_RUN;
                        w_hold[i]      = 1'b1;
                    end
                    default: begin
                        w_state_nxt[i] = ST_SET;
                        w_alert_nxt[i] = 1'b0;
                    end
                endcase
            end else if (w_sel[i] && w_do_cancel && r_state[i] != ST_SET) begin
                w_state_nxt[i] = ST_SET;
                w_cnt_nxt[i]   = r_preset[i];
                w_alert_nxt[i] = 1'b0;
                w_hold[i]      = 1'b1;
            end else if (w_sel[i] && (w_do_inc || w_do_dec) && r_state[i] == ST_SET) begin
                case (r_field)
                    FLD_HOUR: w_preset_nxt[i][23:16] = step_field(r_preset[i][23:16], HMAX, w_do_inc);
                    FLD_MIN:  w_preset_nxt[i][15:8]  = step_field(r_preset[i][15:8], 7'd59, w_do_inc);
                    default:  w_preset_nxt[i][7:0]   = step_field(r_preset[i][7:0], 7'd59, w_do_inc);
                endcase
            end
            if (r_state[i] == ST_RUN && w_tick && !w_hold[i]) begin
                if (r_cnt[i] == 24'h000001) begin
                    w_alert_nxt[i] = 1'b1;
                    if (AUTO_RELOAD) begin
                        w_cnt_nxt[i] = r_preset[i];
                    end else begin
                        w_cnt_nxt[i]   = '0;
                        w_state_nxt[i] = ST_DONE;
                    end
                end else begin
                    w_cnt_nxt[i] = dec_time(r_cnt[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div     <= '0;
            r_ch_sel  <= '0;
            r_field   <= FLD_HOUR;
            r_running <= '0;
            r_alert   <= '0;
            for (int unsigned i = 0; i < unsigned'(CHANNELS); i++) begin
                r_state[i]  <= ST_SET;
                r_preset[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            r_ch_sel <= w_ch_nxt;
            r_field  <= w_field_nxt;
            r_alert  <= w_alert_nxt;
            for (int unsigned i = 0; i < unsigned'(CHANNELS); i++) begin
                r_state[i]   <= w_state_nxt[i];
                r_preset[i]  <= w_preset_nxt[i];
                r_cnt[i]     <= w_cnt_nxt[i];
                r_running[i] <= (w_state_nxt[i] == ST_RUN);
            end
        end
    end

    assign ch_sel     = r_ch_sel;
    assign value      = (r_state[r_ch_sel] == ST_SET) ? r_preset[r_ch_sel] : r_cnt[r_ch_sel];
    assign cursor_pos = (r_state[r_ch_sel] == ST_SET) ? r_field : 2'd0;
    assign running    = r_running;
    assign alert      = r_alert;

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Bench for multi_countdown_timer: one plain and one auto-reload instance share the
// buttons and are checked every cycle against a seconds-based reference model.
module tb_multi_countdown_timer;

    localparam int TD  = 4;
    localparam int NCH = 4;
    localparam int MH  = 99;

    localparam logic [5:0] B_START  = 6'b100000;
    localparam logic [5:0] B_CANCEL = 6'b010000;
    localparam logic [5:0] B_CH     = 6'b001000;
    localparam logic [5:0] B_NEXT   = 6'b000100;
    localparam logic [5:0] B_INC    = 6'b000010;
    localparam logic [5:0] B_DEC    = 6'b000001;

    localparam int S_SET = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       b_start, b_cancel, b_ch, b_next, b_inc, b_dec;
    logic [1:0] ch_sel0, ch_sel1, cur0, cur1;
    logic [23:0] value0, value1;
    logic [3:0] run0, run1, al0, al1;

    multi_countdown_timer #(.TICK_DIV(TD), .CHANNELS(NCH), .MAX_HOUR(MH), .AUTO_RELOAD(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .btn_start(b_start), .btn_cancel(b_cancel), .btn_ch(b_ch),
        .btn_next(b_next), .btn_inc(b_inc), .btn_dec(b_dec), .ch_sel(ch_sel0), .value(value0),
        .cursor_pos(cur0), .running(run0), .alert(al0));

    multi_countdown_timer #(.TICK_DIV(TD), .CHANNELS(NCH), .MAX_HOUR(MH), .AUTO_RELOAD(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .btn_start(b_start), .btn_cancel(b_cancel), .btn_ch(b_ch),
        .btn_next(b_next), .btn_inc(b_inc), .btn_dec(b_dec), .ch_sel(ch_sel1), .value(value1),
        .cursor_pos(cur1), .running(run1), .alert(al1));

    // Reference model: presets as h/m/s integers, counters as total seconds.
    int m_st  [2][NCH];
    int m_ph  [2][NCH];
    int m_pm  [2][NCH];
    int m_ps  [2][NCH];
    int m_cnt [2][NCH];
    bit m_al  [2][NCH];
    int m_sel, m_fld;
    int ncyc, nticks;
    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int preset_secs(input int k, input int c);
        return m_ph[k][c] * 3600 + m_pm[k][c] * 60 + m_ps[k][c];
    endfunction

    function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int wrap(input int v, input int mx, input bit up);
        if (up) return (v == mx) ? 0 : v + 1;
        return (v == 0) ? mx : v - 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++) begin
                m_st[k][c] = S_SET; m_ph[k][c] = 0; m_pm[k][c] = 0; m_ps[k][c] = 0;
                m_cnt[k][c] = 0; m_al[k][c] = 1'b0;
            end
        m_sel = 0;
        m_fld = 0;
    endtask

    task automatic model_edge(input logic [5:0] b, input bit tick);
        int act;
        act = -1;
        for (int j = 0; j < 6; j++) if (b[j]) act = j;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++) begin
                int old;
                bit held;
                old  = m_st[k][c];
                held = 1'b0;
                if (c == m_sel) begin
                    if (act == 5) begin
                        if (old == S_SET && preset_secs(k, c) != 0) begin
                            m_st[k][c] = S_RUN; m_cnt[k][c] = preset_secs(k, c); held = 1'b1;
                        end else if (old == S_RUN && m_al[k][c]) begin
                            m_al[k][c] = 1'b0;
                        end else if (old == S_RUN) begin
                            m_st[k][c] = S_PAUSE; held = 1'b1;
                        end else if (old == S_PAUSE) begin
                            m_st[k][c] = S_RUN; held = 1'b1;
                        end else if (old == S_DONE) begin
                            m_st[k][c] = S_SET; m_al[k][c] = 1'b0;
                        end
                    end else if (act == 4 && old != S_SET) begin
                        m_st[k][c] = S_SET; m_cnt[k][c] = preset_secs(k, c);
                        m_al[k][c] = 1'b0; held = 1'b1;
                    end else if ((act == 1 || act == 0) && old == S_SET) begin
                        if (m_fld == 0)      m_ph[k][c] = wrap(m_ph[k][c], MH, act == 1);
                        else if (m_fld == 1) m_pm[k][c] = wrap(m_pm[k][c], 59, act == 1);
                        else                 m_ps[k][c] = wrap(m_ps[k][c], 59, act == 1);
                    end
                end
                if (old == S_RUN && tick && !held) begin
                    if (m_cnt[k][c] == 1) begin
                        m_al[k][c] = 1'b1;
                        if (k == 1) m_cnt[k][c] = preset_secs(k, c);
                        else begin m_cnt[k][c] = 0; m_st[k][c] = S_DONE; end
                    end else begin
                        m_cnt[k][c]--;
                    end
                end
            end
        if (act == 3) begin
            m_sel = (m_sel + 1) % NCH;
            m_fld = 0;
        end else if (act == 2) begin
            m_fld = (m_fld + 1) % 3;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic [23:0] ev;
            logic [3:0]  er, ea;
            logic [1:0]  ec;
            int          c;
            c  = m_sel;
            ev = (m_st[k][c] == S_SET) ? to_bcd(m_ph[k][c], m_pm[k][c], m_ps[k][c])
                                        : to_bcd(m_cnt[k][c] / 3600, (m_cnt[k][c] / 60) % 60, m_cnt[k][c] % 60);
            ec = (m_st[k][c] == S_SET) ? 2'(m_fld + 1) : 2'd0;
            for (int j = 0; j < NCH; j++) begin
                er[j] = (m_st[k][j] == S_RUN);
                ea[j] = m_al[k][j];
            end
            chk($sformatf("i%0d ch_sel", k), 32'(k ? ch_sel1 : ch_sel0), 32'(m_sel));
            chk($sformatf("i%0d value", k),  32'(k ? value1 : value0),   32'(ev));
            chk($sformatf("i%0d cursor", k), 32'(k ? cur1 : cur0),       32'(ec));
            chk($sformatf("i%0d running", k), 32'(k ? run1 : run0),      32'(er));
            chk($sformatf("i%0d alert", k),  32'(k ? al1 : al0),         32'(ea));
        end
    endtask

    task automatic step(input logic [5:0] b);
        bit tk;
        {b_start, b_cancel, b_ch, b_next, b_inc, b_dec} = b;
        tk = (ncyc % TD) == TD - 1;
        @(posedge clk);
        model_edge(b, tk);
        ncyc++;
        if (tk) nticks++;
        @(negedge clk);
        {b_start, b_cancel, b_ch, b_next, b_inc, b_dec} = '0;
        compare_all();
    endtask

    task automatic press(input logic [5:0] b, input int n);
        repeat (n) step(b);
    endtask

    task automatic wait_ticks(input int n);
        int t0;
        t0 = nticks;
        while (nticks - t0 < n) step('0);
    endtask

    task automatic align_tick();
        while (ncyc % TD != TD - 1) step('0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        reset = 1'b0;
        {b_start, b_cancel, b_ch, b_next, b_inc, b_dec} = '0;
        model_reset();
        ncyc = 0;
        nticks = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        compare_all();
        chk("reset value", 32'(value0), 32'h0);
        chk("reset cursor", 32'(cur0), 32'd1);

        // Preset 02:01:00, 61 s of countdown.
        press(B_INC, 2);
        step(B_NEXT);
        step(B_INC);
        step(B_START);
        wait_ticks(61);
        chk("61 ticks value", 32'(value0), 32'h015959);
        chk("61 ticks running", 32'(run0[0]), 32'd1);

        // Asynchronous reset while channel 0 counts.
        #2 reset = 1'b0;
        #1;
        chk("async rst value", 32'(value0), 32'h0);
        chk("async rst cursor", 32'(cur0), 32'd1);
        chk("async rst running", 32'(run0), 32'h0);
        chk("async rst alert", 32'(al1), 32'h0);
        chk("async rst ch_sel", 32'(ch_sel0), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        ncyc = 0;
        compare_all();

        // Preset 00:00:02 to expiry, then acknowledge.
        press(B_NEXT, 2);
        press(B_INC, 2);
        step(B_NEXT);
        step(B_START);
        wait_ticks(2);
        chk("expire alert", 32'(al0[0]), 32'd1);
        chk("expire value", 32'(value0), 32'h0);
        chk("expire running", 32'(run0[0]), 32'd0);
        step(B_START);
        chk("ack alert", 32'(al0[0]), 32'd0);
        chk("ack cursor", 32'(cur0), 32'd1);
        chk("ack value", 32'(value0), 32'h000002);

        // Channel 1 expires while channel 2 is selected.
        step(B_CH);
        press(B_NEXT, 2);
        press(B_INC, 5);
        step(B_START);
        t0 = nticks;
        step(B_CH);
        wait_ticks(5 - (nticks - t0));
        chk("bg alert ch1", 32'(al0[1]), 32'd1);
        chk("bg ch_sel", 32'(ch_sel0), 32'd2);
        chk("bg ch2 value", 32'(value0), 32'h0);
        chk("bg ch2 alert", 32'(al0[2]), 32'd0);
        step(B_DEC);
        chk("dec hour wrap", 32'(value0), 32'h990000);

        // Pause coinciding with a tick at 00:00:10.
        step(B_INC);
        chk("inc hour wrap", 32'(value0), 32'h0);
        press(B_NEXT, 2);
        press(B_INC, 10);
        step(B_START);
        align_tick();
        step(B_START);
        chk("pause+tick value", 32'(value0), 32'h000010);
        chk("pause+tick running", 32'(run0[2]), 32'd0);
        wait_ticks(3);
        chk("paused hold", 32'(value0), 32'h000010);
        step(B_START);
        chk("resume running", 32'(run0[2]), 32'd1);

        // Auto-reload instance, preset 00:00:01.
        step(B_CH);
        press(B_NEXT, 2);
        step(B_INC);
        step(B_START);
        wait_ticks(1);
        chk("reload alert", 32'(al1[3]), 32'd1);
        chk("reload value", 32'(value1), 32'h000001);
        chk("reload running", 32'(run1[3]), 32'd1);
        chk("plain done alert", 32'(al0[3]), 32'd1);
        step(B_START);
        chk("reload ack alert", 32'(al1[3]), 32'd0);
        chk("reload ack running", 32'(run1[3]), 32'd1);

        // Random button traffic, including simultaneous presses.
        repeat (4000) begin
            logic [5:0] b;
            int r;
            r = $urandom_range(0, 99);
            if (r < 50)      b = '0;
            else if (r < 92) b = 6'(1 << $urandom_range(0, 5));
            else             b = 6'($urandom);
            step(b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_countdown_timer.md
Name: multi_countdown_timer

Overview:
- Parametrised successor to the single-channel HH:MM:SS countdown timer.
- Holds CHANNELS independent BCD countdown timers, each with its own preset, run/pause control, optional auto-reload and a latched alarm.
- One channel is selected at a time for editing and display. The selected channel's value and cursor drive the existing 7-segment display path.
- Sits between the button debouncers and the display mux, next to the clock/alarm blocks.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per 1 s tick. Benches use a small value such as 4.
- CHANNELS, 4: number of timers, range 1..8.
- MAX_HOUR, 99: largest settable hour, range 1..99.
- AUTO_RELOAD, 0: 1 = on expiry, reload the preset and keep running.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_start  in  1  one-cycle pulse: start/pause/resume/acknowledge on the selected channel
- btn_cancel  in  1  one-cycle pulse: abort the selected channel back to SET
- btn_ch  in  1  one-cycle pulse: select the next channel
- btn_next  in  1  one-cycle pulse: move the edit cursor
- btn_inc  in  1  one-cycle pulse: increment the field under the cursor
- btn_dec  in  1  one-cycle pulse: decrement the field under the cursor
- ch_sel  out  $clog2(CHANNELS) (min 1)  selected channel index
- value  out  24  BCD of the selected channel: [23:20]=hour10, [19:16]=hour1, [15:12]=min10, [11:8]=min1, [7:4]=sec10, [3:0]=sec1
- cursor_pos  out  2  0=none, 1=hour, 2=min, 3=sec
- running  out  CHANNELS  bit i = channel i in RUN
- alert  out  CHANNELS  bit i = channel i expired; latched until acknowledged

Behaviour:
- Reset (reset=0, asynchronous):
  - all presets and counters 00:00:00, all channels in SET;
  - ch_sel=0, internal edit field=hour, tick divider=0;
  - running=0, alert=0, value=0, cursor_pos=1.
- Tick generation: free-running divider, one-cycle tick every TICK_DIV clks, shared by all channels.
- Per-channel state machine: SET, RUN, PAUSE, DONE.
  - SET + start + preset≠0 → RUN; counter loaded from preset. Start with preset=0 is ignored.
  - RUN + start → PAUSE. PAUSE + start → RUN. Counter is held while in PAUSE.
  - RUN/PAUSE + cancel → SET; counter reloaded from preset.
  - DONE + start or cancel → SET; alert bit cleared the same cycle.
  - RUN + tick: counter decrements by 1 s with BCD borrow across fields (sec 0→59 borrows from min, min 0→59 borrows from hour).
  - Counter reaching 00:00:00 on a tick: alert[i] set the next cycle.
    - AUTO_RELOAD=0: channel → DONE.
    - AUTO_RELOAD=1: counter reloaded from preset, channel stays in RUN, alert stays latched until start. In this case start first acknowledges the alert (alert cleared, stays RUN); the following start pauses.
- Buttons act only on the selected channel. Unselected channels keep counting.
- Editing:
  - inc/dec modify only the selected channel's preset, and only while it is in SET.
  - Fields wrap independently with no carry into neighbouring fields: sec and min 0..59, hour 0..MAX_HOUR. Inc at max → 0; dec at 0 → max.
  - btn_next cycles hour→min→sec→hour.
- btn_ch: ch_sel increments and wraps CHANNELS-1→0; the edit field resets to hour.
- Same-cycle button priority: start > cancel > ch > next > inc > dec; lower-priority buttons in that cycle are dropped.
- Tick and start in the same cycle:
  - SET→RUN: counter loads the preset; no decrement that cycle.
  - RUN→PAUSE: the pause wins; no decrement.
- Outputs:
  - value shows the preset in SET and the counter otherwise (combinational mux of registered state).
  - cursor_pos is the field code when the selected channel is in SET, else 0.
  - running and alert are registered.
- Latency:
  - button pulse → state/registers updated on the next clk edge;
  - expiry tick → alert bit high 1 cycle later.

Test Plan:
- Reset low mid-run with channel 0 counting → all outputs return to reset values immediately, asynchronously; after release value=000000, cursor_pos=1.
- Channel 0: inc hour 2×, next, inc min 1× (preset 02:01:00), start, 61 ticks → value=0x015959, running[0]=1.
- Preset 00:00:02, start, 2 ticks → alert[0]=1, state DONE, value=000000; start → alert[0]=0, cursor_pos=1, value shows preset 000002.
- Channel 1 preset 00:00:05 running; btn_ch to channel 2; 5 ticks → alert[1]=1 while ch_sel=2 and channel 2 unchanged; dec hour on channel 2 → hour 99.
- start + tick in the same cycle while RUN at 00:00:10 → PAUSE, value stays 0x000010; 3 further ticks → no change; start → RUN.
- AUTO_RELOAD=1, preset 00:00:01: start, 1 tick → alert=1, value reloads to 000001, running=1; start → alert=0, still RUN.
